// File: rtl/uart_file_responder_pkg.sv
// Shared constants, state encoding and the on-chip file memory map for uart_file_responder.
package uart_file_pkg;

    localparam logic [7:0] HDR_READ  = 8'h52;
    localparam logic [7:0] HDR_WRITE = 8'h57;

    typedef logic [3:0] state_t;
    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_IDX_LO  = 4'd1;
    localparam state_t S_IDX_HI  = 4'd2;
    localparam state_t S_LOOKUP  = 4'd3;
    localparam state_t S_RD_ADDR = 4'd4;
    localparam state_t S_RD_DATA = 4'd5;
    localparam state_t S_RD_SEND = 4'd6;
    localparam state_t S_RD_ACK  = 4'd7;
    localparam state_t S_WR_RECV = 4'd8;
    localparam state_t S_WR_SUM  = 4'd9;
    localparam state_t S_DONE    = 4'd10;

    typedef enum logic {RW_READ = 1'b0, RW_WRITE = 1'b1} rw_t;

    // Memory map: 80 image files of 784 bytes, 48 result files of 16 bytes, one empty file.
    localparam int unsigned IMG_FILES = 80;
    localparam int unsigned IMG_LEN   = 784;
    localparam int unsigned RES_FILES = 48;
    localparam int unsigned RES_LEN   = 16;
    localparam int unsigned RES_BASE  = IMG_FILES * IMG_LEN;

    function automatic int unsigned file_base(input int unsigned idx);
        if (idx < IMG_FILES) return idx * IMG_LEN;
        else if (idx < IMG_FILES + RES_FILES) return RES_BASE + (idx - IMG_FILES) * RES_LEN;
        else return RES_BASE + RES_FILES * RES_LEN;
    endfunction

    function automatic int unsigned file_len(input int unsigned idx);
        if (idx < IMG_FILES) return IMG_LEN;
        else if (idx < IMG_FILES + RES_FILES) return RES_LEN;
        else return 0;
    endfunction

endpackage

// File: rtl/uart_file_responder_file_table.sv
// Combinational file index -> {base, len} lookup over the shared memory map.
module file_table
    import uart_file_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 16
) (
    input  logic [IDX_W-1:0]  idx_i,
    output logic [ADDR_W-1:0] base_o,
    output logic [ADDR_W-1:0] len_o
);

    always_comb begin
        base_o = ADDR_W'(file_base(32'(idx_i)));
        len_o  = ADDR_W'(file_len(32'(idx_i)));
    end

endmodule

// File: rtl/uart_file_responder.sv
// Responder end of the R/W byte-serial file protocol, emulating the host file store on-chip.
// Define RESP_CHECKSUM_EN for an XOR trailer byte in both directions (adds err_sum_o).
module uart_file_responder
    import uart_file_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int NUM_FILES = 129,
    parameter int IDX_W     = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_rdy_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_en_o,
    input  logic              tx_busy_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mem_we_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_cmd_o,
`ifdef RESP_CHECKSUM_EN
    output logic              err_sum_o,
`endif
    output logic              err_idx_o
);

    state_t            state_q, state_d;
    rw_t               rw_q, rw_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d, mem_addr_q, mem_addr_d;
    logic [7:0]        tx_data_q, tx_data_d, mem_wdata_q, mem_wdata_d, sum_q, sum_d;
    logic              rx_rdy_q, tx_en_q, tx_en_d, mem_we_q, mem_we_d;
    logic              busy_q, busy_d, done_q, done_d, err_cmd_q, err_cmd_d, err_idx_q, err_idx_d;
    logic              seen_q, seen_d, trailer_q, trailer_d, err_sum_q, err_sum_d;
    logic [ADDR_W-1:0] tbl_base, tbl_len;
    logic              rx_acc;

    file_table #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_file_table (
        .idx_i  (idx_q),
        .base_o (tbl_base),
        .len_o  (tbl_len)
    );

    assign rx_acc = rx_rdy_i && !rx_rdy_q;

    always_comb begin
        state_d = state_q;   rw_d = rw_q;       idx_d = idx_q;
        ptr_d = ptr_q;       cnt_d = cnt_q;     mem_addr_d = mem_addr_q;
        tx_data_d = tx_data_q; mem_wdata_d = mem_wdata_q; sum_d = sum_q;
        busy_d = busy_q;     seen_d = seen_q;   trailer_d = trailer_q;
        tx_en_d = 1'b0;      mem_we_d = 1'b0;   done_d = 1'b0;
        err_cmd_d = 1'b0;    err_idx_d = 1'b0;  err_sum_d = 1'b0;
        case (state_q)
            S_IDLE: if (rx_acc) begin
                if (rx_data_i == HDR_READ) begin
                    rw_d = RW_READ;  state_d = S_IDX_LO;
                end else if (rx_data_i == HDR_WRITE) begin
                    rw_d = RW_WRITE; state_d = S_IDX_LO;
                end else begin
                    err_cmd_d = 1'b1;
                end
            end
            S_IDX_LO: if (rx_acc) begin
                idx_d = {idx_q[IDX_W-1:8], rx_data_i};
                state_d = S_IDX_HI;
            end
            S_IDX_HI: if (rx_acc) begin
                idx_d = {rx_data_i, idx_q[7:0]};
                state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (idx_q >= IDX_W'(NUM_FILES)) begin
                    err_idx_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // mem_addr is preloaded so the synchronous read lands in RD_DATA
                    ptr_d = tbl_base;  cnt_d = tbl_len;  mem_addr_d = tbl_base;
                    busy_d = 1'b1;     sum_d = 8'h00;    trailer_d = 1'b0;
                    if (tbl_len == '0)       state_d = S_DONE;
                    else if (rw_q == RW_READ) state_d = S_RD_ADDR;
                    else                      state_d = S_WR_RECV;
                end
            end
            S_RD_ADDR: begin
                mem_addr_d = ptr_q;
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                tx_data_d = mem_rdata_i;
                sum_d = sum_q ^ mem_rdata_i;
                state_d = S_RD_SEND;
            end
            S_RD_SEND: if (!tx_busy_i) begin
                tx_en_d = 1'b1;
                seen_d = 1'b0;
                state_d = S_RD_ACK;
            end
            S_RD_ACK: begin
                if (tx_busy_i) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    if (trailer_q) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;  cnt_d = cnt_q - 1'b1;  mem_addr_d = ptr_q + 1'b1;
                        if (cnt_q == ADDR_W'(1)) begin
`ifdef RESP_CHECKSUM_EN
                            trailer_d = 1'b1;
                            tx_data_d = sum_q;
                            state_d = S_RD_SEND;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_RD_ADDR;
                        end
                    end
                end
            end
            S_WR_RECV: if (rx_acc) begin
                mem_addr_d = ptr_q;  mem_wdata_d = rx_data_i;  mem_we_d = 1'b1;
                ptr_d = ptr_q + 1'b1;  cnt_d = cnt_q - 1'b1;  sum_d = sum_q ^ rx_data_i;
                if (cnt_q == ADDR_W'(1)) begin
`ifdef RESP_CHECKSUM_EN
                    state_d = S_WR_SUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef RESP_CHECKSUM_EN
            S_WR_SUM: if (rx_acc) begin
                if (rx_data_i == sum_q) begin
                    state_d = S_DONE;
                end else begin
                    err_sum_d = 1'b1;  busy_d = 1'b0;  state_d = S_IDLE;
                end
            end
`endif
            S_DONE: begin
                done_d = 1'b1;  busy_d = 1'b0;  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;   rw_q <= RW_READ;  idx_q <= '0;
            ptr_q <= '0;         cnt_q <= '0;      mem_addr_q <= '0;
            tx_data_q <= '0;     mem_wdata_q <= '0; sum_q <= '0;
            rx_rdy_q <= 1'b0;    tx_en_q <= 1'b0;  mem_we_q <= 1'b0;
            busy_q <= 1'b0;      done_q <= 1'b0;   err_cmd_q <= 1'b0;
            err_idx_q <= 1'b0;   seen_q <= 1'b0;   trailer_q <= 1'b0;
            err_sum_q <= 1'b0;
        end else begin
            state_q <= state_d;  rw_q <= rw_d;     idx_q <= idx_d;
            ptr_q <= ptr_d;      cnt_q <= cnt_d;   mem_addr_q <= mem_addr_d;
            tx_data_q <= tx_data_d; mem_wdata_q <= mem_wdata_d; sum_q <= sum_d;
            rx_rdy_q <= rx_rdy_i; tx_en_q <= tx_en_d; mem_we_q <= mem_we_d;
            busy_q <= busy_d;    done_q <= done_d; err_cmd_q <= err_cmd_d;
            err_idx_q <= err_idx_d; seen_q <= seen_d; trailer_q <= trailer_d;
            err_sum_q <= err_sum_d;
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_en_o     = tx_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_cmd_o   = err_cmd_q;
    assign err_idx_o   = err_idx_q;
`ifdef RESP_CHECKSUM_EN
    assign err_sum_o   = err_sum_q;
`endif

endmodule

// File: doc/uart_file_responder.md
Name: uart_file_responder

Overview:
- Responder end of the byte-serial file protocol used by the accelerator FSM:
  - header 'R' (0x52) or 'W' (0x57);
  - 16-bit file index, LSB first;
  - then data bytes.
- On 'R' it streams the file's bytes out of local storage. On 'W' it captures the file's bytes into local storage.
- Sits behind an rs232 instance. It emulates the host file store on-chip for loopback bring-up and for simulation of the main FSM.

Parameters:
- ADDR_W, 16, storage byte-address width.
- NUM_FILES, 129, valid file indices are 0..NUM_FILES-1.
- IDX_W, 16, file index width on the wire; fixed at 2 bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from rs232
- rx_rdy  in  1  rs232 byte-ready; level, possibly held multiple cycles
- tx_data  out  8  byte to rs232
- tx_en  out  1  one-cycle transmit strobe
- tx_busy  in  1  rs232 transmitter busy
- mem_addr  out  ADDR_W  storage byte address
- mem_wdata  out  8  storage write data
- mem_we  out  1  storage write enable, one cycle per byte
- mem_rdata  in  8  storage read data, valid 1 cycle after mem_addr (synchronous read)
- busy  out  1  high from header accepted until transfer done or aborted
- done  out  1  one-cycle pulse at end of a successful transfer
- err_cmd  out  1  one-cycle pulse: header byte not 'R'/'W'
- err_idx  out  1  one-cycle pulse: index >= NUM_FILES

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE;
  - all outputs 0: tx_data, tx_en, mem_*, busy, done, err_*;
  - rx edge register cleared.
  - Reset mid-transfer aborts immediately. No partial cleanup; already-written bytes remain in storage.
- Byte accept: a received byte is consumed on the rising edge of rx_rdy (registered previous value). A held rx_rdy counts once.
- States:
  - IDLE: on byte 0x52 -> latch rw=READ, go IDX_LO. On byte 0x57 -> latch rw=WRITE, go IDX_LO. Any other byte -> err_cmd pulse, stay IDLE.
  - IDX_LO: next byte -> idx[7:0]. Go IDX_HI.
  - IDX_HI: next byte -> idx[15:8]. Go LOOKUP.
  - LOOKUP (1 cycle): if idx >= NUM_FILES -> err_idx pulse, IDLE, no data exchanged. Else latch base/len from file_table, ptr=base, cnt=len, busy=1. Then RD_ADDR if READ, WR_RECV if WRITE.
  - RD_ADDR: drive mem_addr=ptr. Go RD_DATA.
  - RD_DATA: capture mem_rdata into tx_data. Go RD_SEND.
  - RD_SEND: when tx_busy=0 -> tx_en=1 for one cycle, go RD_ACK.
  - RD_ACK: wait tx_busy=1, then tx_busy=0. rs232 raises tx_busy the cycle after tx_en. Then ptr+=1, cnt-=1. If cnt==0 -> DONE, else RD_ADDR.
  - WR_RECV: each accepted byte -> mem_addr=ptr, mem_wdata=byte, mem_we=1 that cycle, ptr+=1, cnt-=1. If cnt reaches 0 -> DONE.
  - DONE: done pulse, busy=0. Go IDLE.
- Bytes arriving during read states are ignored; the protocol is half-duplex.
- len==0 files are legal: LOOKUP goes directly to DONE.
- ptr/cnt are ADDR_W wide with modulo arithmetic. The file_table guarantees base+len <= 2^ADDR_W; no wrap is checked.
- Throughput:
  - read: one byte per rs232 frame plus 3 cycles;
  - write: limited only by rx_rdy rate.

Optional Feature:
- RESP_CHECKSUM_EN defined:
  - READ: after the last data byte, one extra byte is sent, the XOR of all data bytes sent.
  - WRITE: after len bytes, one extra byte is received and compared with the XOR of the received bytes. On mismatch a new output err_sum pulses, and done does not pulse. Stored bytes are not rolled back.
- Undefined: no trailer byte and no err_sum port. This matches the main FSM as it exists.

Decomposition:
- Package uart_file_pkg:
  - HDR_READ=8'h52, HDR_WRITE=8'h57;
  - state enum;
  - rw enum (READ/WRITE).
- Sub-module file_table: combinational index -> {base[ADDR_W-1:0], len[ADDR_W-1:0]}. Its layout is identical to the project memory map used by file_info, encoded in the same package.

Test Plan:
- Read, file 0 (base 0, len 784, storage[i]=i[7:0]): send 0x52,0x00,0x00 -> 784 tx_en strobes with tx_data 0x00..0xFF repeating, then done pulse, busy=0.
- Write, file 65: send 0x57,0x41,0x00 + 784 bytes 0xA5 -> 784 mem_we pulses at base..base+783 with data 0xA5, then done. A following read of 65 returns 0xA5 x784.
- Bad header: send 0x33 -> err_cmd pulse, no tx_en, still IDLE. A following 0x52,0x01,0x00 is served normally.
- Bad index: send 0x52,0x81,0x00 (129) -> err_idx pulse, zero tx_en, IDLE.
- rx_rdy held 5 cycles per byte during write -> exactly one mem_we per byte. tx_busy stretched to 1000 cycles during read -> no extra tx_en.
- Reset asserted at byte 300 of a read -> outputs 0 immediately. A new 0x52,0x00,0x00 restarts from byte 0.
